// File: rtl/mole_spawner.sv
// Whack-a-mole game sequencer: LFSR-driven one-hot mole placement, visible/gap
// timing, hit/miss scoring and a window that shrinks after every hit.
module mole_spawner #(
    parameter int unsigned TICKS_UP   = 50_000_000,
    parameter int unsigned TICKS_GAP  = 25_000_000,
    parameter int unsigned MIN_UP     = 10_000_000,
    parameter int unsigned UP_STEP    = 2_000_000,
    parameter int unsigned MAX_MISSES = 5,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic        whacked_i,
    output logic [15:0] mole_o,
    output logic [7:0]  hit_count_o,
    output logic [7:0]  miss_count_o,
    output logic        game_over_o
);

    localparam int unsigned TMAX = (TICKS_UP > TICKS_GAP) ? TICKS_UP : TICKS_GAP;
    localparam int          TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] GAP_RELOAD    = TW'(TICKS_GAP - 1);
    localparam logic [TW-1:0] UP_INIT       = TW'(TICKS_UP);
    localparam logic [TW-1:0] MIN_UP_T      = TW'(MIN_UP);
    localparam logic [TW-1:0] UP_STEP_T     = TW'(UP_STEP);
    localparam logic [32:0]   SPEEDUP_FLOOR = 33'(MIN_UP) + 33'(UP_STEP);
    localparam logic [7:0]    MISS_LIMIT    = 8'(MAX_MISSES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_GAP  = 2'd1;
    localparam logic [1:0] S_UP   = 2'd2;
    localparam logic [1:0] S_OVER = 2'd3;

    logic [1:0]    state_q,    state_d;
    logic [TW-1:0] timer_q,    timer_d;
    logic [TW-1:0] cur_up_q,   cur_up_d;
    logic [15:0]   lfsr_q,     lfsr_d;
    logic [3:0]    prev_idx_q, prev_idx_d;
    logic [15:0]   mole_q,     mole_d;
    logic [7:0]    hit_q,      hit_d;
    logic [7:0]    miss_q,     miss_d;
    logic          over_q,     over_d;

    logic [3:0]    idx_raw_s;
    logic [3:0]    idx_pick_s;
    logic [7:0]    miss_inc_s;

    // Hole selection: bump the index by one (mod 16) so a hole never repeats back-to-back
    always_comb begin
        idx_raw_s  = lfsr_q[3:0];
        miss_inc_s = miss_q + 8'd1;
        if (idx_raw_s == prev_idx_q) begin
            idx_pick_s = idx_raw_s + 4'd1;
        end else begin
            idx_pick_s = idx_raw_s;
        end
    end

    // Next-state logic for the round sequencer and the free-running LFSR
    always_comb begin
        lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        state_d    = state_q;
        timer_d    = timer_q;
        cur_up_d   = cur_up_q;
        prev_idx_d = prev_idx_q;
        mole_d     = mole_q;
        hit_d      = hit_q;
        miss_d     = miss_q;
        over_d     = over_q;

        case (state_q)
            S_IDLE, S_OVER: begin
                mole_d = 16'h0000;
                if (start_i) begin
                    state_d  = S_GAP;
                    timer_d  = GAP_RELOAD;
                    cur_up_d = UP_INIT;
                    hit_d    = 8'd0;
                    miss_d   = 8'd0;
                    over_d   = 1'b0;
                end else begin
                    over_d   = (state_q == S_OVER);
                end
            end
            S_GAP: begin
                mole_d = 16'h0000;
                if (timer_q != '0) begin
                    timer_d = timer_q - 1'b1;
                end else begin
                    mole_d     = 16'h0001 << idx_pick_s;
                    prev_idx_d = idx_pick_s;
                    timer_d    = cur_up_q - 1'b1;
                    state_d    = S_UP;
                end
            end
            S_UP: begin
                if (whacked_i) begin
                    // A whack beats a simultaneous timeout
                    if (hit_q != 8'hFF) begin
                        hit_d = hit_q + 8'd1;
                    end else begin
                        hit_d = hit_q;
                    end
                    if (33'(cur_up_q) >= SPEEDUP_FLOOR) begin
                        cur_up_d = cur_up_q - UP_STEP_T;
                    end else begin
                        cur_up_d = MIN_UP_T;
                    end
                    mole_d  = 16'h0000;
                    timer_d = GAP_RELOAD;
                    state_d = S_GAP;
                end else if (timer_q == '0) begin
                    miss_d = miss_inc_s;
                    mole_d = 16'h0000;
                    if (miss_inc_s == MISS_LIMIT) begin
                        state_d = S_OVER;
                        over_d  = 1'b1;
                    end else begin
                        timer_d = GAP_RELOAD;
                        state_d = S_GAP;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                mole_d  = 16'h0000;
                over_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            cur_up_q   <= UP_INIT;
            lfsr_q     <= LFSR_SEED;
            prev_idx_q <= 4'd0;
            mole_q     <= 16'h0000;
            hit_q      <= 8'd0;
            miss_q     <= 8'd0;
            over_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            cur_up_q   <= cur_up_d;
            lfsr_q     <= lfsr_d;
            prev_idx_q <= prev_idx_d;
            mole_q     <= mole_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
            over_q     <= over_d;
        end
    end

    assign mole_o       = mole_q;
    assign hit_count_o  = hit_q;
    assign miss_count_o = miss_q;
    assign game_over_o  = over_q;

endmodule

// File: tb/tb_mole_spawner.sv
// Directed self-checking bench for mole_spawner with a short-window configuration.
module tb_mole_spawner;

    logic        clock_i   = 1'b0;
    logic        reset_i   = 1'b1;
    logic        start_i   = 1'b0;
    logic        whacked_i = 1'b0;
    logic [15:0] mole_o;
    logic [7:0]  hit_count_o;
    logic [7:0]  miss_count_o;
    logic        game_over_o;

    int n_cmp = 0;
    int n_bad = 0;

    mole_spawner #(
        .TICKS_UP   (8),
        .TICKS_GAP  (4),
        .MIN_UP     (4),
        .UP_STEP    (2),
        .MAX_MISSES (3),
        .LFSR_SEED  (16'hACE1)
    ) dut (
        .clock_i      (clock_i),
        .reset_i      (reset_i),
        .start_i      (start_i),
        .whacked_i    (whacked_i),
        .mole_o       (mole_o),
        .hit_count_o  (hit_count_o),
        .miss_count_o (miss_count_o),
        .game_over_o  (game_over_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    // Counts samples with mole_o==0; returns on the first sample showing a mole.
    task automatic count_zero(input string tag, output int n);
        n = 0;
        while (mole_o == 16'h0000 && n < 64) begin
            n++;
            tick();
        end
        if (n >= 64) check_eq({tag, "_timeout"}, n, 0);
        check_eq({tag, "_onehot"}, {31'd0, $onehot(mole_o)}, 32'd1);
    endtask

    // Counts samples with a mole visible; checks the mole stays constant.
    task automatic count_up(input string tag, output int n);
        logic [15:0] m0;
        int          unstable;
        m0       = mole_o;
        unstable = 0;
        n        = 0;
        while (mole_o != 16'h0000 && n < 64) begin
            if (mole_o !== m0) unstable++;
            n++;
            tick();
        end
        check_eq({tag, "_stable"}, unstable, 0);
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic whack_on_cycle(input int c);
        for (int k = 1; k < c; k++) tick();
        whacked_i = 1'b1;
        tick();
        whacked_i = 1'b0;
    endtask

    function automatic int onehot_idx(input logic [15:0] m);
        int r;
        r = -1;
        for (int b = 0; b < 16; b++) begin
            if (m[b]) r = b;
        end
        return r;
    endfunction

    initial begin
        int          n;
        int          idx;
        int          prev;
        logic [15:0] seen;

        // Reset and idle
        tick();
        tick();
        reset_i = 1'b0;
        check_eq("reset_outs", {mole_o, hit_count_o, miss_count_o}, 32'd0);
        check_eq("reset_over", {31'd0, game_over_o}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            tick();
            check_eq("idle_outs", {mole_o, hit_count_o, miss_count_o, 7'd0, game_over_o} >> 0, 32'd0);
        end

        // Start and miss
        pulse_start();
        count_zero("gap0", n);   check_eq("gap0_len", n, 4);
        count_up("up0", n);      check_eq("up0_len", n, 8);
        check_eq("miss_after_up0", {24'd0, miss_count_o}, 32'd1);
        check_eq("hit_after_up0", {24'd0, hit_count_o}, 32'd0);
        count_zero("gap1", n);   check_eq("gap1_len", n, 4);

        // Hit on the 3rd visible cycle
        whack_on_cycle(3);
        check_eq("hit1_mole", {16'd0, mole_o}, 32'd0);
        check_eq("hit1_count", {24'd0, hit_count_o}, 32'd1);
        whacked_i = 1'b1;
        tick();
        whacked_i = 1'b0;
        check_eq("gap_whack_ignored", {24'd0, hit_count_o}, 32'd1);
        pulse_start();
        check_eq("gap_start_ignored", {16'd0, hit_count_o, miss_count_o}, {16'd0, 8'd1, 8'd1});
        count_zero("gap2", n);   check_eq("gap2_rest", n, 2);

        // Shortened window after one hit
        count_up("up2", n);      check_eq("up_after_1hit", n, 6);
        check_eq("miss2", {24'd0, miss_count_o}, 32'd2);
        count_zero("gap3", n);   check_eq("gap3_len", n, 4);
        whack_on_cycle(1);
        check_eq("hit2_count", {24'd0, hit_count_o}, 32'd2);
        count_zero("gap4", n);   check_eq("gap4_len", n, 4);
        whack_on_cycle(1);
        check_eq("hit3_count", {24'd0, hit_count_o}, 32'd3);
        count_zero("gap5", n);

        // Whack on the final cycle of a 4-cycle window
        whack_on_cycle(4);
        check_eq("simul_hit", {24'd0, hit_count_o}, 32'd4);
        check_eq("simul_miss", {24'd0, miss_count_o}, 32'd2);
        check_eq("simul_mole", {16'd0, mole_o}, 32'd0);
        count_zero("gap6", n);

        // Third miss ends the round
        count_up("up_floor", n); check_eq("up_floor_len", n, 4);
        check_eq("over_flag", {31'd0, game_over_o}, 32'd1);
        check_eq("over_miss", {24'd0, miss_count_o}, 32'd3);
        whacked_i = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        whacked_i = 1'b0;
        check_eq("over_hold", {mole_o, hit_count_o, miss_count_o}, {16'd0, 8'd4, 8'd3});
        check_eq("over_hold_flag", {31'd0, game_over_o}, 32'd1);

        // Restart, then three straight misses at the full window
        pulse_start();
        check_eq("restart_counts", {16'd0, hit_count_o, miss_count_o}, 32'd0);
        check_eq("restart_over", {31'd0, game_over_o}, 32'd0);
        for (int r = 0; r < 3; r++) begin
            count_zero("r2_gap", n); check_eq("r2_gap_len", n, 4);
            count_up("r2_up", n);    check_eq("r2_up_len", n, 8);
        end
        check_eq("r2_over", {31'd0, game_over_o}, 32'd1);
        check_eq("r2_miss", {24'd0, miss_count_o}, 32'd3);

        // Reset while a mole is visible
        pulse_start();
        count_zero("r3_gap", n); check_eq("r3_gap_len", n, 4);
        tick();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        check_eq("midreset_outs", {mole_o, hit_count_o, miss_count_o}, 32'd0);
        check_eq("midreset_over", {31'd0, game_over_o}, 32'd0);
        for (int i = 0; i < 6; i++) tick();
        check_eq("midreset_idle", {16'd0, mole_o}, 32'd0);

        // Long run: index rule, coverage of all holes, hit saturation
        prev = 0;
        seen = 16'h0000;
        pulse_start();
        for (int i = 0; i < 260; i++) begin
            count_zero("loop_gap", n);
            check_eq("loop_gap_len", n, 4);
            idx = onehot_idx(mole_o);
            check_eq("idx_repeat", (idx == prev) ? 32'd1 : 32'd0, 32'd0);
            seen = seen | mole_o;
            prev = idx;
            whack_on_cycle(1);
        end
        check_eq("all_holes", {16'd0, seen}, 32'h0000FFFF);
        check_eq("hit_saturate", {24'd0, hit_count_o}, 32'd255);
        check_eq("loop_miss", {24'd0, miss_count_o}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
